// File: rtl/mem_arbiter.sv
// Byte-serial owner of the single-port RAM bus, shared by instruction fetch and the load/store buffer.
// Define MEMCTRL_IO_STALL_EN to hold IO-space write bytes while the UART TX buffer is full.
module mem_arbiter #(
  parameter int         ADDR_WIDTH   = 32,
  parameter logic [1:0] IO_SPACE_TAG = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_request_in,
  input  logic [ADDR_WIDTH-1:0] if_address_in,
  output logic                  if_ready_out,
  output logic [31:0]           if_data_out,
  input  logic                  lsb_request_in,
  input  logic                  lsb_rw_in,
  input  logic [ADDR_WIDTH-1:0] lsb_address_in,
  input  logic [2:0]            lsb_goal_in,
  input  logic [31:0]           lsb_data_in,
  output logic                  lsb_ready_out,
  output logic [31:0]           lsb_data_out,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_e;

  function automatic logic [2:0] goal_bytes(input logic [2:0] goal);
    case (goal)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic                  if_pend_q, lsb_pend_q;
  logic [ADDR_WIDTH-1:0] if_pend_addr_q, lsb_pend_addr_q;
  logic                  lsb_pend_rw_q;
  logic [2:0]            lsb_pend_goal_q;
  logic [31:0]           lsb_pend_data_q;
  logic                  port_lsb_q;
  logic [2:0]            nbytes_q, idx_q;
  logic [31:0]           wdata_q, rbuf_q, rbuf_d;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            mem_dout_q;
  logic                  mem_wr_q;
  logic                  if_ready_q, lsb_ready_q;
  logic [31:0]           if_rdata_q, lsb_rdata_q;

  logic                  lsb_want, if_want, start_lsb, start_if;
  logic                  req_rw;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_n;
  logic [31:0]           req_data;
  logic                  last_rd, last_wr, io_stall;
  logic [1:0]            rd_lane;

  // A pulse arriving while the port is selectable bypasses its pending latch.
  assign lsb_want  = lsb_pend_q | lsb_request_in;
  assign if_want   = if_pend_q | if_request_in;
  assign start_lsb = (state_q == IDLE) & lsb_want;
  assign start_if  = (state_q == IDLE) & ~lsb_want & if_want;
  assign last_rd   = (idx_q == nbytes_q);
  assign last_wr   = ((idx_q + 3'd1) == nbytes_q);
  assign rd_lane   = idx_q[1:0] - 2'd1;

`ifdef MEMCTRL_IO_STALL_EN
  assign io_stall = (state_q == WRITE) && io_buffer_full && (mem_a_q[17:16] == IO_SPACE_TAG);
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  always_comb begin
    req_rw   = 1'b0;
    req_addr = if_pend_q ? if_pend_addr_q : if_address_in;
    req_n    = 3'd4;
    req_data = '0;
    if (lsb_want) begin
      req_rw   = lsb_pend_q ? lsb_pend_rw_q : lsb_rw_in;
      req_addr = lsb_pend_q ? lsb_pend_addr_q : lsb_address_in;
      req_n    = goal_bytes(lsb_pend_q ? lsb_pend_goal_q : lsb_goal_in);
      req_data = lsb_pend_q ? lsb_pend_data_q : lsb_data_in;
    end
  end

  // mem_din carries the byte addressed one cycle earlier, so lane idx-1 fills while idx is driven.
  always_comb begin
    rbuf_d = rbuf_q;
    if ((state_q == READ) && (idx_q != 3'd0)) begin
      rbuf_d[{rd_lane, 3'b000} +: 8] = mem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_lsb)     state_d = req_rw ? WRITE : READ;
        else if (start_if) state_d = READ;
      end
      READ:    if (last_rd) state_d = IDLE;
      WRITE:   if (!io_stall && last_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_wr        = mem_wr_q & ~io_stall;
    mem_a         = mem_a_q;
    mem_dout      = mem_dout_q;
    if_ready_out  = if_ready_q;
    if_data_out   = if_rdata_q;
    lsb_ready_out = lsb_ready_q;
    lsb_data_out  = lsb_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pend_q   <= 1'b0;
      lsb_pend_q  <= 1'b0;
      idx_q       <= 3'd0;
      mem_wr_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      lsb_rdata_q <= '0;
    end else begin
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      rbuf_q      <= rbuf_d;
      if (start_lsb) begin
        lsb_pend_q <= 1'b0;
      end else if (lsb_request_in && !lsb_pend_q) begin
        lsb_pend_q      <= 1'b1;
        lsb_pend_rw_q   <= lsb_rw_in;
        lsb_pend_addr_q <= lsb_address_in;
        lsb_pend_goal_q <= lsb_goal_in;
        lsb_pend_data_q <= lsb_data_in;
      end
      if (start_if) begin
        if_pend_q <= 1'b0;
      end else if (if_request_in && !if_pend_q) begin
        if_pend_q      <= 1'b1;
        if_pend_addr_q <= if_address_in;
      end
      case (state_q)
        IDLE: begin
          if (start_lsb || start_if) begin
            port_lsb_q <= start_lsb;
            nbytes_q   <= req_n;
            idx_q      <= 3'd0;
            wdata_q    <= req_data;
            rbuf_q     <= '0;
            mem_a_q    <= req_addr;
            mem_wr_q   <= req_rw;
            mem_dout_q <= req_data[7:0];
          end
        end
        READ: begin
          if (last_rd) begin
            if (port_lsb_q) begin
              lsb_ready_q <= 1'b1;
              lsb_rdata_q <= rbuf_d;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= rbuf_d;
            end
          end else begin
            idx_q <= idx_q + 3'd1;
            if ((idx_q + 3'd1) < nbytes_q) mem_a_q <= mem_a_q + ADDR_WIDTH'(1);
          end
        end
        WRITE: begin
          if (!io_stall) begin
            if (last_wr) begin
              mem_wr_q    <= 1'b0;
              lsb_ready_q <= 1'b1;
            end else begin
              idx_q      <= idx_q + 3'd1;
              mem_a_q    <= mem_a_q + ADDR_WIDTH'(1);
              mem_dout_q <= wdata_q[{idx_q[1:0] + 2'd1, 3'b000} +: 8];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-level bus expectations and ready pulses are queued at
// stimulus time from a reference memory and retired as the arbiter drives the bus.
module tb_mem_arbiter;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_request_in, if_ready_out;
  logic [AW-1:0] if_address_in;
  logic [31:0]   if_data_out;
  logic          lsb_request_in, lsb_rw_in, lsb_ready_out;
  logic [AW-1:0] lsb_address_in;
  logic [2:0]    lsb_goal_in;
  logic [31:0]   lsb_data_in, lsb_data_out;
  logic [7:0]    mem_din = 8'h00;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;
  logic          io_buffer_full;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .IO_SPACE_TAG(2'b11)) dut (
    .clk(clk), .rst(rst),
    .if_request_in(if_request_in), .if_address_in(if_address_in),
    .if_ready_out(if_ready_out), .if_data_out(if_data_out),
    .lsb_request_in(lsb_request_in), .lsb_rw_in(lsb_rw_in),
    .lsb_address_in(lsb_address_in), .lsb_goal_in(lsb_goal_in),
    .lsb_data_in(lsb_data_in), .lsb_ready_out(lsb_ready_out),
    .lsb_data_out(lsb_data_out), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  typedef struct { int cyc; logic [31:0] addr; logic wr; logic [7:0] data; } bus_t;
  typedef struct { int cyc; logic [31:0] data; logic chk_data; } rdy_t;

  bus_t busq[$];
  rdy_t lsbq[$];
  rdy_t ifq[$];
  logic [7:0] ram  [logic [31:0]];
  logic [7:0] refm [logic [31:0]];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_miss = 0;
  bit  mon_en = 1'b0;

  function automatic logic [7:0] pat(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : pat(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : pat(a);
  endfunction

  function automatic int nbytes(input logic [2:0] g);
    return (g == 3'd1) ? 1 : (g == 3'd2) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bus(input int c, input logic [31:0] a, input logic wr, input logic [7:0] d);
    bus_t b;
    b = '{c, a, wr, d};
    busq.push_back(b);
  endtask

  task automatic expect_access(input bit is_lsb, input bit wr, input logic [31:0] addr,
                               input int n, input logic [31:0] data, input int c, input int stall);
    logic [31:0] rd;
    logic [31:0] a;
    rdy_t r;
    rd = '0;
    for (int k = 0; k < n; k++) begin
      a = addr + k;
      if (wr) begin
        refm[a] = data[8*k +: 8];
        push_bus(c + 1 + stall + k, a, 1'b1, data[8*k +: 8]);
      end else begin
        rd[8*k +: 8] = ref_rd(a);
        push_bus(c + 1 + k, a, 1'b0, 8'h00);
      end
    end
    r = '{(wr ? c + n + 1 + stall : c + n + 2), rd, !wr};
    if (is_lsb) lsbq.push_back(r);
    else        ifq.push_back(r);
  endtask

  task automatic lsb_set(input bit wr, input logic [31:0] a, input logic [2:0] g, input logic [31:0] d);
    lsb_request_in = 1'b1;
    lsb_rw_in      = wr;
    lsb_address_in = a;
    lsb_goal_in    = g;
    lsb_data_in    = d;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((busq.size() + lsbq.size() + ifq.size()) != 0 && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) begin
      check("drain_timeout", 32'(busq.size() + lsbq.size() + ifq.size()), 32'd0);
      busq.delete();
      lsbq.delete();
      ifq.delete();
    end
  endtask

  task automatic lsb_op(input bit wr, input logic [31:0] a, input logic [2:0] g,
                        input logic [31:0] d, input int stall);
    lsb_set(wr, a, g, d);
    expect_access(1'b1, wr, a, nbytes(g), d, cyc, stall);
    tick();
    lsb_request_in = 1'b0;
    drain();
  endtask

  // RAM: registered read of the previous-cycle address, write on mem_wr.
  initial forever begin
    @(posedge clk);
    mem_din <= ram_rd(mem_a);
    if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    if (rst === 1'b0) begin
      assert (!(lsb_request_in && lsbq.size() > 1)) else $error("lsb pulse while lsb request outstanding");
      assert (!(if_request_in && ifq.size() > 1)) else $error("fetch pulse while fetch outstanding");
    end
  end

  initial begin
    bus_t b;
    rdy_t r;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (busq.size() > 0 && busq[0].cyc == cyc) begin
          b = busq.pop_front();
          check("bus_addr", mem_a, b.addr);
          check("bus_wr", 32'(mem_wr), 32'(b.wr));
          if (b.wr) check("bus_dout", 32'(mem_dout), 32'(b.data));
        end else begin
          check("idle_wr", 32'(mem_wr), 32'd0);
          if (busq.size() > 0 && busq[0].cyc < cyc) begin
            check("bus_missed_cycle", 32'(cyc), 32'(busq[0].cyc));
            void'(busq.pop_front());
          end
        end
        if (lsb_ready_out) begin
          if (lsbq.size() == 0) check("lsb_unexpected_ready", 32'(lsb_ready_out), 32'd0);
          else begin
            r = lsbq.pop_front();
            check("lsb_ready_cycle", 32'(cyc), 32'(r.cyc));
            if (r.chk_data) check("lsb_data", lsb_data_out, r.data);
          end
        end else if (lsbq.size() > 0 && lsbq[0].cyc <= cyc) begin
          check("lsb_ready_missing", 32'(lsb_ready_out), 32'd1);
          void'(lsbq.pop_front());
        end
        if (if_ready_out) begin
          if (ifq.size() == 0) check("if_unexpected_ready", 32'(if_ready_out), 32'd0);
          else begin
            r = ifq.pop_front();
            check("if_ready_cycle", 32'(cyc), 32'(r.cyc));
            check("if_data", if_data_out, r.data);
          end
        end else if (ifq.size() > 0 && ifq[0].cyc <= cyc) begin
          check("if_ready_missing", 32'(if_ready_out), 32'd1);
          void'(ifq.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int st;
    logic [2:0] goals [8];
    goals = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd7, 3'd2, 3'd4};
    rst = 1'b1;
    if_request_in = 1'b0; if_address_in = '0;
    lsb_request_in = 1'b0; lsb_rw_in = 1'b0; lsb_address_in = '0;
    lsb_goal_in = 3'd0; lsb_data_in = '0; io_buffer_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ram[32'h100 + k]  = 8'h11 * (k + 1);
      refm[32'h100 + k] = 8'h11 * (k + 1);
    end
    repeat (3) tick();
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_if_ready", 32'(if_ready_out), 32'd0);
    check("rst_if_data", if_data_out, 32'd0);
    check("rst_lsb_ready", 32'(lsb_ready_out), 32'd0);
    check("rst_lsb_data", lsb_data_out, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick();

    lsb_op(1'b0, 32'h100, 3'd4, 32'h0, 0);
    lsb_op(1'b1, 32'h201, 3'd2, 32'hDEADBEEF, 0);
    lsb_op(1'b0, 32'h200, 3'd4, 32'h0, 0);

    // Same-cycle collision: LB first, fetch starts on the LB ready cycle.
    lsb_set(1'b0, 32'h10, 3'd1, 32'h0);
    if_request_in = 1'b1; if_address_in = 32'h0;
    c = cyc;
    expect_access(1'b1, 1'b0, 32'h10, 1, 32'h0, c, 0);
    expect_access(1'b0, 1'b0, 32'h0, 4, 32'h0, c + 3, 0);
    tick();
    lsb_request_in = 1'b0; if_request_in = 1'b0;
    drain();

    // Fetch arriving while a word load is busy.
    lsb_set(1'b0, 32'h40, 3'd4, 32'h0);
    c = cyc;
    expect_access(1'b1, 1'b0, 32'h40, 4, 32'h0, c, 0);
    tick();
    lsb_request_in = 1'b0;
    tick();
    if_request_in = 1'b1; if_address_in = 32'h80;
    expect_access(1'b0, 1'b0, 32'h80, 4, 32'h0, c + 6, 0);
    tick();
    if_request_in = 1'b0;
    drain();

    // Reset during a word store, with a fetch pending.
    lsb_set(1'b1, 32'h300, 3'd4, 32'h12345678);
    c = cyc;
    push_bus(c + 1, 32'h300, 1'b1, 8'h78);
    push_bus(c + 2, 32'h301, 1'b1, 8'h56);
    refm[32'h300] = 8'h78;
    refm[32'h301] = 8'h56;
    tick();
    lsb_request_in = 1'b0;
    if_request_in = 1'b1; if_address_in = 32'h500;
    tick();
    if_request_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_mem_a", mem_a, 32'd0);
    repeat (6) tick();
    check("rst_pending_cleared", mem_a, 32'd0);
    lsb_op(1'b0, 32'h300, 3'd2, 32'h0, 0);

    // Store byte to IO space while the TX buffer reports full.
`ifdef MEMCTRL_IO_STALL_EN
    st = 3;
`else
    st = 0;
`endif
    io_buffer_full = 1'b1;
    lsb_set(1'b1, 32'h30000, 3'd1, 32'h000000A5);
    expect_access(1'b1, 1'b1, 32'h30000, 1, 32'h000000A5, cyc, st);
    tick();
    lsb_request_in = 1'b0;
    tick();
    tick();
    tick();
    io_buffer_full = 1'b0;
    drain();
    io_buffer_full = 1'b1;
    lsb_op(1'b0, 32'h30000, 3'd1, 32'h0, 0);
    io_buffer_full = 1'b0;

    for (int i = 0; i < 8; i++) begin
      lsb_op(i[0], (i == 5) ? 32'hFFFF_FFFE : 32'h1000 + $urandom_range(0, 63),
             goals[i], $urandom, 0);
    end
    lsb_op(1'b0, 32'hFFFF_FFFE, 3'd4, 32'h0, 0);

    if_request_in = 1'b1; if_address_in = 32'h1000;
    expect_access(1'b0, 1'b0, 32'h1000, 4, 32'h0, cyc, 0);
    tick();
    if_request_in = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single owner of the byte-wide, single-port RAM bus.
- Shares that bus between two requesters: instruction fetch (always word reads) and the load/store buffer (1/2/4-byte reads and writes).
- Latches single-cycle request pulses, arbitrates with load/store buffer priority, sequences each access byte by byte, and returns a one-cycle ready pulse with zero-extended data.

Parameters:
- ADDR_WIDTH, 32, width of request and RAM addresses.
- IO_SPACE_TAG, 2'b11, value of address bits [17:16] that marks memory-mapped IO (0x30000 and up).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- if_request_in  input  1  one-cycle pulse: fetch a 4-byte word.
- if_address_in  input  ADDR_WIDTH  fetch address, valid with the pulse.
- if_ready_out  output  1  one-cycle pulse: fetch complete.
- if_data_out  output  32  fetched word, little-endian; valid while if_ready_out is high.
- lsb_request_in  input  1  one-cycle pulse: load/store request.
- lsb_rw_in  input  1  0 = load, 1 = store.
- lsb_address_in  input  ADDR_WIDTH  byte address of the access.
- lsb_goal_in  input  3  byte count: 1 = byte, 2 = halfword, 4 = word; other values are treated as 4.
- lsb_data_in  input  32  store data; bytes taken from bit 0 upward.
- lsb_ready_out  output  1  one-cycle pulse: load data valid or store done.
- lsb_data_out  output  32  load data, zero-extended.
- mem_din  input  8  RAM read byte; presents the byte for the address driven on the previous cycle.
- mem_dout  output  8  RAM write byte.
- mem_a  output  ADDR_WIDTH  RAM byte address.
- mem_wr  output  1  1 = write mem_dout to mem_a this cycle.
- io_buffer_full  input  1  UART TX buffer full; used only with the optional feature.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, both pending flags cleared. A reset mid-transfer abandons the access, and no ready pulse is produced.
- Pending latches:
  - A request pulse copies its address, rw, goal and data into that port's pending register and sets the pending flag.
  - A second pulse on a port whose flag is already set is ignored; this is a protocol violation and the bench asserts on it.
  - A pulse arriving in the same cycle the arbiter selects that port is started directly and does not need a separate pending cycle.
- Arbitration, checked only in IDLE, including the cycle that carries a ready pulse:
  - The load/store buffer wins over fetch.
  - Simultaneous pulses: the load/store access goes first, and fetch stays pending.
- States:
  - IDLE → READ or WRITE when a request is selected.
  - READ or WRITE → IDLE after the last byte.
- Request timing: a request accepted at the edge ending cycle c drives byte 0 (mem_a = A) in cycle c+1. Byte k is driven in cycle c+1+k at address A+k, computed modulo 2^ADDR_WIDTH.
- READ, N bytes:
  - mem_wr stays 0.
  - Byte k is sampled from mem_din in cycle c+2+k and placed into bits [8k+7:8k].
  - Ready pulses in cycle c+N+2, so LW = 6 cycles after the request cycle and LB = 3.
  - Unfilled upper bits are 0.
- WRITE, N bytes:
  - mem_wr = 1 and mem_dout = data[8k+7:8k] in cycle c+1+k.
  - Ready pulses in cycle c+N+1, with mem_wr already 0.
- Idle bus: mem_wr = 0 and mem_a holds its last value. mem_wr is never high outside WRITE.
- Back-to-back: if the other port is pending, its byte 0 is driven in the cycle after the ready pulse; there are no bubble cycles beyond that.
- Data outputs: hold their values between pulses and are only meaningful while ready is high.

Optional Feature:
- Macro: MEMCTRL_IO_STALL_EN.
- Defined:
  - Before driving any write byte whose address has bits [17:16] == IO_SPACE_TAG while io_buffer_full = 1, the arbiter stalls.
  - During the stall mem_wr = 0 and the byte index is held.
  - It resumes the cycle after io_buffer_full falls.
  - Ready latency extends by the stall cycles.
  - Reads to IO space never stall.
- Undefined: io_buffer_full is ignored and all timing is as above.

Test Plan:
- LW: lsb pulse, addr 0x100, RAM bytes 0x11/0x22/0x33/0x44 → mem_a 0x100..0x103 in cycles 1..4; lsb_ready in cycle 6 with data 0x44332211.
- SH: lsb pulse, addr 0x201, data 0xDEADBEEF, goal 2 → mem_wr = 1 for exactly 2 cycles, writing 0xEF@0x201 and 0xBE@0x202; ready in cycle 3.
- Collision: lsb LB at 0x10 and fetch at 0x0 pulsed in the same cycle → LB completes first, ready in cycle 3; fetch byte 0 drives in cycle 4 and if_ready arrives in cycle 9.
- Fetch pulse while an LW is busy → fetch is latched and starts in the cycle after lsb_ready; the word returned is correct.
- Reset asserted in cycle 2 of an SW → mem_wr = 0 from the next cycle, no ready pulse, pending flags cleared, and a new request afterwards works.
- With MEMCTRL_IO_STALL_EN: SB to 0x30000 with io_buffer_full high for 3 cycles → mem_wr is held low for 3 cycles, then writes once; ready in cycle 5.
